// File: rtl/seq_div_counter.sv
// Loadable down-counter whose count can also be divided in place by an operand
// through a multi-cycle restoring divider. COUNTER_SATURATE_EN holds dec at zero.
module seq_div_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             div,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] rem,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [0:0]    IDLE   = 1'b0;
    localparam logic [0:0]    DIVIDE = 1'b1;
    localparam logic [IW-1:0] LAST   = IW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] part;
    logic [IW-1:0]    iter;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] next_part;
    logic [WIDTH-1:0] next_quo;

    // quo starts as the dividend and shifts quotient bits in from the LSB as
    // dividend bits leave from the MSB.
    always_comb begin
        trial     = {part, quo[WIDTH-1]};
        ge        = (trial >= {1'b0, dvsr});
        next_part = ge ? (trial[WIDTH-1:0] - dvsr) : trial[WIDTH-1:0];
        next_quo  = {quo[WIDTH-2:0], ge};
    end

    assign zero = (count == '0);
    assign busy = (state == DIVIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            rem   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            quo   <= '0;
            dvsr  <= '0;
            part  <= '0;
            iter  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (latch) begin
                        count <= in;
                    end else if (div) begin
                        if (in == '0) begin
                            err <= 1'b1;
                        end else begin
                            quo   <= count;
                            dvsr  <= in;
                            part  <= '0;
                            iter  <= '0;
                            state <= DIVIDE;
                        end
                    end else if (dec) begin
`ifdef COUNTER_SATURATE_EN
                        if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end
`else
                        count <= count - WIDTH'(1);
`endif
                    end
                end
                DIVIDE: begin
                    quo  <= next_quo;
                    part <= next_part;
                    iter <= iter + IW'(1);
                    if (iter == LAST) begin
                        count <= next_quo;
                        rem   <= next_part;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_counter.sv
// Directed plus randomized bench for seq_div_counter (WIDTH=8) against a
// reference model built on the / and % operators.
module tb_seq_div_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         latch, div, dec;
  logic [W-1:0] count, rem;
  logic         zero, busy, done, err;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [W-1:0] m_count, m_rem;

  seq_div_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in(in), .latch(latch), .div(div), .dec(dec),
    .count(count), .rem(rem), .zero(zero), .busy(busy), .done(done), .err(err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs are sampled at the next posedge, outputs read 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic d, input logic c, input logic [W-1:0] v);
    latch = l; div = d; dec = c; in = v;
  endtask

  task automatic idle_inputs();
    latch = 1'b0; div = 1'b0; dec = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".rem"},   32'(rem),   32'(m_rem));
    check({tag, ".zero"},  32'(zero),  32'(m_count == 0));
    check({tag, ".busy"},  32'(busy),  0);
  endtask

  function automatic logic [W-1:0] dec_model(input logic [W-1:0] c);
`ifdef COUNTER_SATURATE_EN
    return (c == 0) ? c : W'(c - 1);
`else
    return W'((int'(c) + (1 << W) - 1) % (1 << W));
`endif
  endfunction

  // Runs the WIDTH busy cycles after an accepted div, hammering the inputs with
  // junk commands, then checks the result against integer division.
  task automatic run_division(input string tag, input logic [W-1:0] divisor, input bit junk);
    logic [W-1:0] q, r;
    q = m_count / divisor;
    r = m_count % divisor;
    check({tag, ".busy_e0"}, 32'(busy), 1);
    check({tag, ".done_e0"}, 32'(done), 0);
    for (int k = 1; k <= W; k++) begin
      if (junk) drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), W'($urandom));
      step();
      if (k < W) begin
        check({tag, ".busy_mid"},  32'(busy),  1);
        check({tag, ".count_mid"}, 32'(count), 32'(m_count));
      end
    end
    idle_inputs();
    m_count = q;
    m_rem   = r;
    check({tag, ".busy_end"},  32'(busy),  0);
    check({tag, ".done_end"},  32'(done),  1);
    check({tag, ".count_end"}, 32'(count), 32'(q));
    check({tag, ".rem_end"},   32'(rem),   32'(r));
  endtask

  initial begin
    logic [W-1:0] v;
    bit l, d, c;

    // Reset then idle
    reset = 1'b1; idle_inputs(); in = '0;
    step(); step();
    reset = 1'b0;
    check("rst.count", 32'(count), 0);
    check("rst.rem",   32'(rem),   0);
    check("rst.zero",  32'(zero),  1);
    check("rst.busy",  32'(busy),  0);
    check("rst.done",  32'(done),  0);
    check("rst.err",   32'(err),   0);

    drive(1, 0, 0, 16); step(); idle_inputs();
    check("latch16.count", 32'(count), 16);
    check("latch16.zero",  32'(zero),  0);

    // 200 / 7 with dec asserted and in scrambled during the division
    drive(1, 0, 0, 200); step();
    drive(0, 1, 0, 7);   step(); idle_inputs();
    check("d200.busy1", 32'(busy), 1);
    for (int k = 1; k <= W; k++) begin
      drive(0, 0, 1, W'($urandom));
      step();
      if (k < W) check("d200.busy", 32'(busy), 1);
      if (k < W) check("d200.count_hold", 32'(count), 200);
    end
    idle_inputs();
    check("d200.count", 32'(count), 28);
    check("d200.rem",   32'(rem),   4);
    check("d200.done",  32'(done),  1);
    check("d200.busy0", 32'(busy),  0);
    step();
    check("d200.done_pulse", 32'(done), 0);
    check("d200.count_kept", 32'(count), 28);

    // Decrement to zero and past it
    drive(1, 0, 0, 1); step();
    drive(0, 0, 1, 0); step();
    check("dec1.count", 32'(count), 0);
    check("dec1.zero",  32'(zero),  1);
    step(); idle_inputs();
`ifdef COUNTER_SATURATE_EN
    check("dec0.count", 32'(count), 0);
`else
    check("dec0.count", 32'(count), 255);
`endif

    // Divide by zero
    drive(1, 0, 0, 5); step();
    drive(0, 1, 0, 0); step(); idle_inputs();
    check("dz.err",   32'(err),   1);
    check("dz.busy",  32'(busy),  0);
    check("dz.count", 32'(count), 5);
    check("dz.rem",   32'(rem),   4);
    step();
    check("dz.err_pulse", 32'(err), 0);
    check("dz.busy2",     32'(busy), 0);

    // Reset during the 4th busy cycle
    drive(1, 0, 0, 100); step();
    drive(0, 1, 0, 3);   step(); idle_inputs();
    step(); step(); step();
    check("abort.busy_before", 32'(busy), 1);
    reset = 1'b1; step(); reset = 1'b0;
    check("abort.count", 32'(count), 0);
    check("abort.rem",   32'(rem),   0);
    check("abort.busy",  32'(busy),  0);
    check("abort.done",  32'(done),  0);
    for (int k = 0; k < W; k++) begin
      step();
      check("abort.no_done", 32'(done), 0);
    end

    // 9 / 9
    m_count = 9; m_rem = 0;
    drive(1, 0, 0, 9); step();
    drive(0, 1, 0, 9); step(); idle_inputs();
    run_division("d9", 9, 0);

    // Priority: latch wins over div and dec
    drive(1, 1, 1, 12); step(); idle_inputs();
    check("prio.count", 32'(count), 12);
    check("prio.busy",  32'(busy),  0);
    step();
    check("prio.busy2", 32'(busy), 0);
    check("prio.done",  32'(done), 0);

    // Back-to-back divisions: second div sampled in the done cycle
    m_count = 12;
    drive(0, 1, 0, 2); step(); idle_inputs();
    run_division("b2b1", 2, 0);
    drive(0, 1, 0, 2); step(); idle_inputs();
    run_division("b2b2", 2, 0);

    // Randomized commands against the model
    for (int n = 0; n < 300; n++) begin
      l = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 1) == 1);
      v = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      drive(l, d, c, v);
      step();
      idle_inputs();
      if (l) begin
        m_count = v;
        check_idle_outputs("rnd.latch");
      end else if (d && v == 0) begin
        check("rnd.dz_err", 32'(err), 1);
        check_idle_outputs("rnd.dz");
      end else if (d) begin
        run_division("rnd.div", v, 1);
      end else begin
        if (c) m_count = dec_model(m_count);
        check_idle_outputs("rnd.dec");
        check("rnd.err", 32'(err), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
